// File: rtl/bank_load_pkg.sv
// ============================================================================
// Module      : bank_load_pkg
// Description : Shared types and sizing for the bank load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bank_load_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam int NTT_ADDR_W = 10;
    localparam int MSM_ADDR_W = 12;

    localparam int NTT_MAX   = 1024;
    localparam int BG4_P_NUM = 384;
    localparam int BG5_P_NUM = 128;
    // Bank groups 0-3 hold 2048 points; groups 4 and 5 hold the remainder.
    localparam int MSM_MAX   = 2 * NTT_MAX + BG4_P_NUM + BG5_P_NUM;

    function automatic logic [MSM_ADDR_W-1:0] eff_len(
        input logic                  is_msm,
        input logic [MSM_ADDR_W-1:0] len
    );
        logic [MSM_ADDR_W-1:0] lim;
        lim = is_msm ? MSM_ADDR_W'(MSM_MAX) : MSM_ADDR_W'(NTT_MAX);
        return (len > lim) ? lim : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bank_load_seq_if.sv
// ============================================================================
// Module      : bank_load_seq_if
// Description : DMA beat stream in, router load command bus out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bank_load_seq_if
    import bank_load_pkg::*;
#(
    parameter int WIDTH_DATA_LOAD = 512
) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH_DATA_LOAD-1:0] in_data;

    logic                       bg_sel;
    logic                       flag_msm;
    logic [NTT_ADDR_W-1:0]      ntt_load_addr;
    logic                       ntt_load_en;
    logic                       ntt_load_wen;
    logic [MSM_ADDR_W-1:0]      msm_load_addr;
    logic                       msm_load_en;
    logic                       msm_load_wen;
    logic [WIDTH_DATA_LOAD-1:0] data_load_in;

    modport master (
        input  in_valid, in_data,
        output in_ready, bg_sel, flag_msm,
        output ntt_load_addr, ntt_load_en, ntt_load_wen,
        output msm_load_addr, msm_load_en, msm_load_wen,
        output data_load_in
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, bg_sel, flag_msm,
        input  ntt_load_addr, ntt_load_en, ntt_load_wen,
        input  msm_load_addr, msm_load_en, msm_load_wen,
        input  data_load_in
    );

endinterface

`default_nettype wire

// File: rtl/bank_load_seq.sv
// ============================================================================
// Module      : bank_load_seq
// Description : Turns a DMA beat stream into NTT/MSM router write commands.
//               Optional BANK_LOAD_SEQ_PERF_EN adds a stall_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_load_seq
    import bank_load_pkg::*;
#(
    parameter int WIDTH_DATA_LOAD = 512
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    input  wire logic                  abort,
    input  wire logic                  cfg_flag_msm,
    input  wire logic                  cfg_bg_sel,
    input  wire logic [MSM_ADDR_W-1:0] cfg_len,
    output logic                       busy,
    output logic                       done,
`ifdef BANK_LOAD_SEQ_PERF_EN
    output logic [31:0]                stall_cnt,
`endif
    bank_load_seq_if.master            bus
);

    state_t                     state_q, state_d;
    logic [MSM_ADDR_W-1:0]      len_q, len_d;
    logic [MSM_ADDR_W-1:0]      cnt_q, cnt_d;
    logic                       flag_msm_q, flag_msm_d;
    logic                       bg_sel_q, bg_sel_d;
    logic [NTT_ADDR_W-1:0]      ntt_addr_q, ntt_addr_d;
    logic                       ntt_en_q, ntt_en_d;
    logic [MSM_ADDR_W-1:0]      msm_addr_q, msm_addr_d;
    logic                       msm_en_q, msm_en_d;
    logic [WIDTH_DATA_LOAD-1:0] data_q, data_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [MSM_ADDR_W-1:0]      start_len;
    logic                       start_accept;
    logic                       in_ready;
    logic                       hs;
    logic                       last_beat;

    assign start_len    = eff_len(cfg_flag_msm, cfg_len);
    assign start_accept = (state_q == ST_IDLE) && start && (start_len != '0);

    // Ready depends only on state and abort, never on in_valid.
    assign in_ready  = (state_q == ST_LOAD) && !abort;
    assign hs        = bus.in_valid && in_ready;
    assign last_beat = hs && (cnt_q == len_q - MSM_ADDR_W'(1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        flag_msm_d = flag_msm_q;
        bg_sel_d   = bg_sel_q;
        ntt_addr_d = '0;
        ntt_en_d   = 1'b0;
        msm_addr_d = '0;
        msm_en_d   = 1'b0;
        data_d     = data_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d    = ST_LOAD;
                    len_d      = start_len;
                    cnt_d      = '0;
                    flag_msm_d = cfg_flag_msm;
                    bg_sel_d   = cfg_bg_sel;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hs) begin
                    data_d = bus.in_data;
                    cnt_d  = cnt_q + MSM_ADDR_W'(1);
                    if (flag_msm_q) begin
                        msm_en_d   = 1'b1;
                        msm_addr_d = cnt_q;
                    end else begin
                        ntt_en_d   = 1'b1;
                        ntt_addr_d = cnt_q[NTT_ADDR_W-1:0];
                    end
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Busy covers the done cycle, but not the zero-length done pulse.
        busy_d = (state_d == ST_LOAD) || last_beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            flag_msm_q <= 1'b0;
            bg_sel_q   <= 1'b0;
            ntt_addr_q <= '0;
            ntt_en_q   <= 1'b0;
            msm_addr_q <= '0;
            msm_en_q   <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            flag_msm_q <= flag_msm_d;
            bg_sel_q   <= bg_sel_d;
            ntt_addr_q <= ntt_addr_d;
            ntt_en_q   <= ntt_en_d;
            msm_addr_q <= msm_addr_d;
            msm_en_q   <= msm_en_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef BANK_LOAD_SEQ_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_accept) begin
            stall_d = '0;
        end else if ((state_q == ST_LOAD) && !bus.in_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign bus.in_ready      = in_ready;
    assign bus.bg_sel        = bg_sel_q;
    assign bus.flag_msm      = flag_msm_q;
    assign bus.ntt_load_addr = ntt_addr_q;
    assign bus.ntt_load_en   = ntt_en_q;
    assign bus.ntt_load_wen  = ntt_en_q;
    assign bus.msm_load_addr = msm_addr_q;
    assign bus.msm_load_en   = msm_en_q;
    assign bus.msm_load_wen  = msm_en_q;
    assign bus.data_load_in  = data_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bank_load_seq.sv
// ============================================================================
// Module      : tb_bank_load_seq
// Description : Scoreboard bench for bank_load_seq with directed jobs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_load_seq;

    localparam int W = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cfg_flag_msm = 1'b0;
    logic        cfg_bg_sel = 1'b0;
    logic [11:0] cfg_len = '0;
    logic        busy;
    logic        done;
`ifdef BANK_LOAD_SEQ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    bank_load_seq_if #(.WIDTH_DATA_LOAD(W)) bus ();

    bank_load_seq #(.WIDTH_DATA_LOAD(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_flag_msm (cfg_flag_msm),
        .cfg_bg_sel   (cfg_bg_sel),
        .cfg_len      (cfg_len),
        .busy         (busy),
        .done         (done),
`ifdef BANK_LOAD_SEQ_PERF_EN
        .stall_cnt    (stall_cnt),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           msm;
        int           addr;
        logic [W-1:0] data;
        longint       cyc;
        bit           last;
    } exp_t;

    exp_t   exp_q[$];
    longint zdone_q[$];
    int     errs = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [W-1:0] mk_data(input int job, input int idx);
        logic [W-1:0] d;
        for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = 32'(job * 65536 + idx + i * 7);
        return d;
    endfunction

    // Scoreboard monitor: every write or done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ntt_load_en || bus.msm_load_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_write: got write at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(e.cyc));
                    chk("write_pair_msm", {63'b0, bus.msm_load_en}, {63'b0, e.msm});
                    if (e.msm) begin
                        chk("msm_wen", {63'b0, bus.msm_load_wen}, 64'd1);
                        chk("msm_addr", {52'b0, bus.msm_load_addr}, 64'(e.addr));
                        chk("ntt_pair_idle", {52'b0, bus.ntt_load_en, bus.ntt_load_wen, bus.ntt_load_addr}, 64'd0);
                    end else begin
                        chk("ntt_wen", {63'b0, bus.ntt_load_wen}, 64'd1);
                        chk("ntt_addr", {54'b0, bus.ntt_load_addr}, 64'(e.addr));
                        chk("msm_pair_idle", {50'b0, bus.msm_load_en, bus.msm_load_wen, bus.msm_load_addr}, 64'd0);
                    end
                    chk_data("write_data", bus.data_load_in, e.data);
                    chk("done_with_write", {63'b0, done}, {63'b0, e.last});
                end
            end else if (done) begin
                if (zdone_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
                end else begin
                    chk("zero_len_done_cycle", 64'(cyc), 64'(zdone_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, {63'b0, bus.in_ready}, 64'd0);
        chk({tag, "_ntt"}, {52'b0, bus.ntt_load_en, bus.ntt_load_wen, bus.ntt_load_addr}, 64'd0);
        chk({tag, "_msm"}, {50'b0, bus.msm_load_en, bus.msm_load_wen, bus.msm_load_addr}, 64'd0);
        chk_data({tag, "_data"}, bus.data_load_in, '0);
        chk({tag, "_cfg"}, {62'b0, bus.flag_msm, bus.bg_sel}, 64'd0);
        chk({tag, "_busy_done"}, {62'b0, busy, done}, 64'd0);
`ifdef BANK_LOAD_SEQ_PERF_EN
        chk({tag, "_stall_cnt"}, {32'b0, stall_cnt}, 64'd0);
`endif
    endtask

    // toggle=1 offers beats on alternate cycles; abort_at/rst_at < 0 disables them.
    task automatic run_job(input int job, input bit msm, input bit bg, input int len,
                           input bit toggle, input int abort_at, input int rst_at);
        int eff;
        int cnt;
        int iter;
        int stalls;
        bit v;
        eff = msm ? ((len > 2560) ? 2560 : len) : ((len > 1024) ? 1024 : len);
        start = 1'b1;
        cfg_flag_msm = msm;
        cfg_bg_sel = bg;
        cfg_len = 12'(len);
        if (eff == 0) zdone_q.push_back(cyc + 1);
        step();
        start = 1'b0;
        cfg_len = '0;
        if (eff == 0) begin
            chk("zero_len_busy", {63'b0, busy}, 64'd0);
            step();
            chk("zero_len_busy_after", {63'b0, busy}, 64'd0);
            chk("zero_len_in_ready", {63'b0, bus.in_ready}, 64'd0);
            return;
        end
        chk("cfg_latched", {62'b0, bus.flag_msm, bus.bg_sel}, {62'b0, msm, bg});
        cnt = 0;
        iter = 0;
        stalls = 0;
        while (cnt < eff) begin
            if (cnt == rst_at) begin
                rst = 1'b1;
                bus.in_valid = 1'b0;
                #1;
                void'(exp_q.pop_back());
                chk_all_zero("async_rst");
                chk("rst_pending_writes", 64'(exp_q.size()), 64'd0);
                step();
                rst = 1'b0;
                return;
            end
            v = toggle ? (iter % 2 == 0) : 1'b1;
            bus.in_valid = v;
            bus.in_data = mk_data(job, cnt);
            if (cnt == abort_at) begin
                abort = 1'b1;
                #1;
                chk("abort_in_ready", {63'b0, bus.in_ready}, 64'd0);
                chk("abort_cycle_busy", {63'b0, busy}, 64'd1);
                step();
                abort = 1'b0;
                bus.in_valid = 1'b0;
                #1;
                chk("post_abort_busy", {63'b0, busy}, 64'd0);
                chk("post_abort_in_ready", {63'b0, bus.in_ready}, 64'd0);
                return;
            end
            #1;
            chk("load_in_ready", {63'b0, bus.in_ready}, 64'd1);
            chk("load_busy", {63'b0, busy}, 64'd1);
            if (v) begin
                exp_q.push_back('{msm: msm, addr: cnt, data: bus.in_data, cyc: cyc + 1,
                                  last: (cnt == eff - 1)});
                cnt++;
            end else begin
                stalls++;
            end
            iter++;
            step();
        end
        // Done cycle: an extra offered beat must be refused.
        bus.in_valid = 1'b1;
        bus.in_data = mk_data(job, 4095);
        #1;
        chk("done_cycle_in_ready", {63'b0, bus.in_ready}, 64'd0);
        chk("done_cycle_busy", {63'b0, busy}, 64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("idle_busy", {63'b0, busy}, 64'd0);
`ifdef BANK_LOAD_SEQ_PERF_EN
        chk("stall_cnt", {32'b0, stall_cnt}, 64'(stalls));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset_idle");

        // abort while idle is ignored
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", {63'b0, busy}, 64'd0);

        run_job(1, 1'b0, 1'b0, 4,    1'b0, -1, -1);
        run_job(2, 1'b1, 1'b1, 3000, 1'b0, -1, -1);
        run_job(3, 1'b0, 1'b1, 4,    1'b1, -1, -1);
        run_job(4, 1'b0, 1'b0, 0,    1'b0, -1, -1);
        run_job(5, 1'b0, 1'b0, 10,   1'b0, 5,  -1);
        run_job(6, 1'b0, 1'b0, 1500, 1'b0, -1, -1);
        run_job(7, 1'b1, 1'b0, 200,  1'b0, -1, 100);
        run_job(8, 1'b1, 1'b0, 2,    1'b0, -1, -1);

        for (int i = 0; i < 5; i++) step();
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        chk("pending_zero_done", 64'(zdone_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
